// File: rtl/ctrl_pkg.sv
// Shared definitions for the instruction arbiter: instruction width,
// FSM encoding and watchdog sizing.
package ctrl_pkg;

  localparam int INSTR_W = 16;
  localparam int WDOG_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  // Requester index carried with a granted instruction.
  typedef struct packed {
    logic               src;
    logic [INSTR_W-1:0] instr;
  } issue_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector: a lone requester always wins, on contention
// the requester that was not granted last wins. Purely combinational.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: gnt gets a default before the case so no path leaves it unassigned
    // (an unassigned path in always_comb infers a latch).
    gnt = 2'b00;
    case (valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/instr_arbiter.sv
// Feeds a 4-phase control unit from two instruction requesters, round-robin,
// with back-to-back reload on completion and a sticky watchdog abort.
module instr_arbiter
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [INSTR_W-1:0] req0_instr,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [INSTR_W-1:0] req1_instr,
  output logic               req1_ready,
  output logic [INSTR_W-1:0] cu_instr,
  output logic               cu_run,
  input  logic               cu_done,
  output logic               busy,
  output logic               grant_id,
  output logic               err,
  output logic [CNT_W-1:0]   done_cnt
);

  state_t            state;
  logic              last_grant;
  logic [WDOG_W-1:0] wdog;
  logic [1:0]        gnt;
  logic              accept_window;
  logic              accept;
  logic              timeout_hit;
  issue_t            issue;

  rr_arbiter2 u_rr (
    .valid ({req1_valid, req0_valid}),
    .last  (last_grant),
    .gnt   (gnt)
  );

  // A slot opens in IDLE, or in EXEC on the completing cycle. Reset closes it
  // so nothing is handed over while the block is being cleared.
  assign accept_window = rst && !err && ((state == IDLE) || cu_done);
  assign req0_ready    = accept_window && gnt[0];
  assign req1_ready    = accept_window && gnt[1];
  assign accept        = req0_ready || req1_ready;

  assign issue.src   = gnt[1];
  assign issue.instr = gnt[1] ? req1_instr : req0_instr;

  // Completion on the last allowed cycle takes priority over the abort.
  assign timeout_hit = (state == EXEC) && !cu_done &&
                       (wdog == WDOG_W'(TIMEOUT - 1));

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cu_run     <= 1'b0;
      busy       <= 1'b0;
      cu_instr   <= '0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      err        <= 1'b0;
      done_cnt   <= '0;
      wdog       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= EXEC;
            cu_run     <= 1'b1;
            busy       <= 1'b1;
            cu_instr   <= issue.instr;
            grant_id   <= issue.src;
            last_grant <= issue.src;
            wdog       <= '0;
          end
        end
        EXEC: begin
          if (cu_done) begin
            done_cnt <= done_cnt + CNT_W'(1);
            wdog     <= '0;
            if (accept) begin
              cu_instr   <= issue.instr;
              grant_id   <= issue.src;
              last_grant <= issue.src;
            end else begin
              state  <= IDLE;
              cu_run <= 1'b0;
              busy   <= 1'b0;
            end
          end else if (timeout_hit) begin
            err    <= 1'b1;
            state  <= IDLE;
            cu_run <= 1'b0;
            busy   <= 1'b0;
            wdog   <= '0;
          end else begin
            wdog <= wdog + WDOG_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          cu_run <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_arbiter.sv
// Self-checking bench for instr_arbiter: expected issues go into a scoreboard
// queue at handshake time and are popped when the control unit is loaded.
module tb_instr_arbiter;
  import ctrl_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0_valid, req1_valid;
  logic [INSTR_W-1:0] req0_instr, req1_instr;
  logic               req0_ready, req1_ready;
  logic [INSTR_W-1:0] cu_instr;
  logic               cu_run, cu_done, busy, grant_id, err;
  logic [CNT_W-1:0]   done_cnt;

  always #5 clk = ~clk;

  instr_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_instr (req0_instr),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_instr (req1_instr),
    .req1_ready (req1_ready),
    .cu_instr   (cu_instr),
    .cu_run     (cu_run),
    .cu_done    (cu_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .err        (err),
    .done_cnt   (done_cnt)
  );

  int     n_checks = 0;
  int     n_fail   = 0;
  issue_t sb[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Expect exactly requester gid to see ready, and record what it hands over.
  task automatic expect_grant(input logic gid);
    issue_t e;
    settle();
    check("req0_ready", 32'(req0_ready), 32'(!gid));
    check("req1_ready", 32'(req1_ready), 32'(gid));
    e.src   = gid;
    e.instr = gid ? req1_instr : req0_instr;
    sb.push_back(e);
  endtask

  task automatic expect_load();
    issue_t e;
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("cu_instr", 32'(cu_instr), 32'(e.instr));
      check("grant_id", 32'(grant_id), 32'(e.src));
    end
    check("cu_run", 32'(cu_run), 1);
    check("busy", 32'(busy), 1);
  endtask

  // Runs EXEC cycles with cu_done on cycle done_at; no valid pending at the end.
  task automatic run_to_done(input int done_at);
    for (int c = 1; c <= done_at; c++) begin
      cu_done = (c == done_at);
      settle();
      if (c < done_at) begin
        check("exec_ready0", 32'(req0_ready), 0);
        check("exec_ready1", 32'(req1_ready), 0);
      end
      step();
    end
    cu_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cu_done = 1'b0;
    step();
    step();
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_cu_run"},   32'(cu_run), 0);
    check({tag, "_cu_instr"}, 32'(cu_instr), 0);
    check({tag, "_busy"},     32'(busy), 0);
    check({tag, "_grant_id"}, 32'(grant_id), 0);
    check({tag, "_err"},      32'(err), 0);
    check({tag, "_done_cnt"}, 32'(done_cnt), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "time limit reached");
  end

  initial begin
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_instr = '0;
    req1_instr = '0;
    cu_done = 1'b0;
    step();
    step();

    // Reset state; readies held low while reset is asserted.
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    settle();
    check("rst_ready0", 32'(req0_ready), 0);
    check("rst_ready1", 32'(req1_ready), 0);
    check_reset_outs("rst");

    // Single requester 0, then completion on the 4th EXEC cycle.
    rst = 1'b1;
    req1_valid = 1'b0;
    req0_instr = 16'h2A04;
    expect_grant(1'b0);
    step();
    req0_valid = 1'b0;
    expect_load();
    run_to_done(4);
    check("single_done_cnt", 32'(done_cnt), 1);
    check("single_cu_run", 32'(cu_run), 0);
    check("single_busy", 32'(busy), 0);

    // Contention, back-to-back: alternating issue, cu_run never drops.
    do_reset();
    req0_instr = 16'h1111;
    req1_instr = 16'h2222;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    expect_grant(1'b0);
    step();
    for (int k = 0; k < 4; k++) begin
      expect_load();
      for (int c = 1; c < 4; c++) begin
        cu_done = 1'b0;
        settle();
        check("b2b_ready0", 32'(req0_ready), 0);
        check("b2b_ready1", 32'(req1_ready), 0);
        step();
        check("b2b_cu_run", 32'(cu_run), 1);
        check("b2b_hold", 32'(cu_instr), (k % 2 == 0) ? 32'h1111 : 32'h2222);
      end
      cu_done = 1'b1;
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle();
      end else begin
        expect_grant((k % 2) == 0);
      end
      step();
      cu_done = 1'b0;
    end
    check("b2b_done_cnt", 32'(done_cnt), 4);
    check("b2b_end_run", 32'(cu_run), 0);

    // Watchdog abort: err exactly TIMEOUT EXEC cycles after entry.
    req0_instr = 16'hBEEF;
    req0_valid = 1'b1;
    expect_grant(1'b0);
    step();
    req0_valid = 1'b0;
    expect_load();
    for (int c = 1; c <= TIMEOUT; c++) begin
      check("wd_err_early", 32'(err), 0);
      check("wd_busy", 32'(busy), 1);
      step();
    end
    check("wd_err", 32'(err), 1);
    check("wd_busy_end", 32'(busy), 0);
    check("wd_run_end", 32'(cu_run), 0);
    check("wd_done_cnt", 32'(done_cnt), 4);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    cu_done = 1'b1;
    settle();
    check("err_ready0", 32'(req0_ready), 0);
    check("err_ready1", 32'(req1_ready), 0);
    step();
    check("err_sticky", 32'(err), 1);
    check("err_idle_busy", 32'(busy), 0);
    check("err_idle_done", 32'(done_cnt), 4);

    // cu_done in IDLE ignored; completion coinciding with timeout wins.
    do_reset();
    cu_done = 1'b1;
    step();
    check("idle_done_ignored", 32'(done_cnt), 0);
    cu_done = 1'b0;
    req0_instr = 16'h0C0C;
    req0_valid = 1'b1;
    expect_grant(1'b0);
    step();
    req0_valid = 1'b0;
    expect_load();
    run_to_done(TIMEOUT);
    check("tie_err", 32'(err), 0);
    check("tie_done_cnt", 32'(done_cnt), 1);
    check("tie_cu_run", 32'(cu_run), 0);

    // Reset during EXEC cycle 2 abandons the instruction.
    req0_instr = 16'h3C3C;
    req0_valid = 1'b1;
    expect_grant(1'b0);
    step();
    req0_valid = 1'b0;
    expect_load();
    step();
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    cu_done = 1'b1;
    settle();
    check("midrst_ready0", 32'(req0_ready), 0);
    check("midrst_ready1", 32'(req1_ready), 0);
    step();
    check_reset_outs("midrst");
    rst = 1'b1;
    cu_done = 1'b0;
    req0_valid = 1'b0;
    req1_instr = 16'h5A5A;
    expect_grant(1'b1);
    step();
    req1_valid = 1'b0;
    expect_load();
    run_to_done(4);
    check("post_rst_done_cnt", 32'(done_cnt), 1);

    // 256 back-to-back completions with random words: counter wraps to 0.
    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_instr = 16'($urandom);
    req1_instr = 16'($urandom);
    expect_grant(1'b0);
    step();
    for (int n = 1; n <= 256; n++) begin
      expect_load();
      cu_done = 1'b1;
      req0_instr = 16'($urandom);
      req1_instr = 16'($urandom);
      if (n == 256) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        settle();
        check("wrap_pre", 32'(done_cnt), 255);
      end else begin
        expect_grant((n % 2) == 1);
      end
      step();
    end
    cu_done = 1'b0;
    check("wrap_post", 32'(done_cnt), 0);
    check("wrap_cu_run", 32'(cu_run), 0);
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
